// File: rtl/fp_simd_arbiter.sv
// Round-robin arbiter sharing one FP_SIMD unit between NUM_REQ requesters; grant 1 cycle after request, response 1 cycle after simd valid.
// Backpressure: requests wait while FP_SIMD is busy or an operation is in flight; a watchdog turns a lost result into an error response.
module fp_simd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SIMD_WIDTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic [NUM_REQ*SIMD_WIDTH*22-1:0] i_in1,
    input  logic [NUM_REQ*SIMD_WIDTH*22-1:0] i_in2,
    input  logic [NUM_REQ*3-1:0]             i_opcode,
    output logic [NUM_REQ-1:0]               o_grant,
    output logic [NUM_REQ-1:0]               o_rsp_valid,
    output logic [SIMD_WIDTH*22-1:0]         o_rsp_data,
    output logic                             o_rsp_err,
    output logic                             o_simd_en,
    output logic [SIMD_WIDTH*22-1:0]         o_simd_in1,
    output logic [SIMD_WIDTH*22-1:0]         o_simd_in2,
    output logic [2:0]                       o_simd_opcode,
    input  logic [SIMD_WIDTH*22-1:0]         i_simd_output,
    input  logic                             i_simd_valid,
    input  logic                             i_simd_busy
);

    localparam int LW = SIMD_WIDTH * 22;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt, owner, owner_nxt, win;
    logic            win_vld, start, timeout_hit;
    logic [PW:0]     idx_sum;
    logic [WW-1:0]   wd, wd_nxt;

    logic [NUM_REQ-1:0] grant_nxt, rsp_valid_nxt;
    logic [LW-1:0]      rsp_data_nxt, simd_in1_nxt, simd_in2_nxt;
    logic               rsp_err_nxt, simd_en_nxt;
    logic [2:0]         simd_opcode_nxt;

    logic [LW-1:0] in1_arr [NUM_REQ];
    logic [LW-1:0] in2_arr [NUM_REQ];
    logic [2:0]    op_arr  [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign in1_arr[k] = i_in1[k*LW +: LW];
        assign in2_arr[k] = i_in2[k*LW +: LW];
        assign op_arr[k]  = i_opcode[k*3 +: 3];
    end

    // First active request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_sum = {1'b0, ptr} + (PW+1)'(i);
            if (idx_sum >= (PW+1)'(NUM_REQ))
                idx_sum = idx_sum - (PW+1)'(NUM_REQ);
            if (!win_vld && i_req[idx_sum[PW-1:0]]) begin
                win     = idx_sum[PW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign start       = (state == IDLE) && win_vld && !i_simd_busy;
    assign timeout_hit = (wd == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (i_simd_valid || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping state.
    always_comb begin
        grant_nxt       = '0;
        simd_en_nxt     = 1'b0;
        rsp_valid_nxt   = '0;
        rsp_data_nxt    = o_rsp_data;
        rsp_err_nxt     = o_rsp_err;
        simd_in1_nxt    = o_simd_in1;
        simd_in2_nxt    = o_simd_in2;
        simd_opcode_nxt = o_simd_opcode;
        ptr_nxt         = ptr;
        owner_nxt       = owner;
        wd_nxt          = wd;
        case (state)
            IDLE: begin
                if (start) begin
                    grant_nxt[win]  = 1'b1;
                    simd_en_nxt     = 1'b1;
                    simd_in1_nxt    = in1_arr[win];
                    simd_in2_nxt    = in2_arr[win];
                    simd_opcode_nxt = op_arr[win];
                    owner_nxt       = win;
                    ptr_nxt         = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
                end
            end
            ISSUE: wd_nxt = '0;
            WAIT: begin
                wd_nxt = wd + WW'(1);
                // A result arriving on the final watchdog cycle still wins over the timeout.
                if (i_simd_valid) begin
                    rsp_valid_nxt[owner] = 1'b1;
                    rsp_data_nxt         = i_simd_output;
                    rsp_err_nxt          = 1'b0;
                end else if (timeout_hit) begin
                    rsp_valid_nxt[owner] = 1'b1;
                    rsp_data_nxt         = '0;
                    rsp_err_nxt          = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_grant       <= '0;
            o_simd_en     <= 1'b0;
            o_rsp_valid   <= '0;
            o_rsp_data    <= '0;
            o_rsp_err     <= 1'b0;
            o_simd_in1    <= '0;
            o_simd_in2    <= '0;
            o_simd_opcode <= '0;
            ptr           <= '0;
            owner         <= '0;
            wd            <= '0;
        end else begin
            o_grant       <= grant_nxt;
            o_simd_en     <= simd_en_nxt;
            o_rsp_valid   <= rsp_valid_nxt;
            o_rsp_data    <= rsp_data_nxt;
            o_rsp_err     <= rsp_err_nxt;
            o_simd_in1    <= simd_in1_nxt;
            o_simd_in2    <= simd_in2_nxt;
            o_simd_opcode <= simd_opcode_nxt;
            ptr           <= ptr_nxt;
            owner         <= owner_nxt;
            wd            <= wd_nxt;
        end
    end

endmodule

// File: tb/tb_fp_simd_arbiter.sv
// Directed bench for fp_simd_arbiter: FP_SIMD side is driven by hand with precomputed results.
module tb_fp_simd_arbiter;

    localparam int NR = 4;
    localparam int SW = 4;
    localparam int LW = SW * 22;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     i_req;
    logic [NR*LW-1:0]  i_in1, i_in2;
    logic [NR*3-1:0]   i_opcode;
    logic [NR-1:0]     o_grant, o_rsp_valid;
    logic [LW-1:0]     o_rsp_data;
    logic              o_rsp_err, o_simd_en;
    logic [LW-1:0]     o_simd_in1, o_simd_in2;
    logic [2:0]        o_simd_opcode;
    logic [LW-1:0]     i_simd_output;
    logic              i_simd_valid, i_simd_busy;

    int n_tests = 0;
    int n_fail  = 0;

    fp_simd_arbiter #(.NUM_REQ(NR), .SIMD_WIDTH(SW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_in1         (i_in1),
        .i_in2         (i_in2),
        .i_opcode      (i_opcode),
        .o_grant       (o_grant),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_err     (o_rsp_err),
        .o_simd_en     (o_simd_en),
        .o_simd_in1    (o_simd_in1),
        .o_simd_in2    (o_simd_in2),
        .o_simd_opcode (o_simd_opcode),
        .i_simd_output (i_simd_output),
        .i_simd_valid  (i_simd_valid),
        .i_simd_busy   (i_simd_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] lane3(input logic [21:0] v);
        return {v, 66'b0};
    endfunction

    task automatic set_op(input int k, input logic [21:0] a, input logic [21:0] b, input logic [2:0] op);
        i_in1[k*LW +: LW] = lane3(a);
        i_in2[k*LW +: LW] = lane3(b);
        i_opcode[k*3 +: 3] = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int n);
        n = 0;
        while (o_grant == '0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_grant"}, LW'(o_grant), '0);
        chk({tag, "_rspv"},  LW'(o_rsp_valid), '0);
        chk({tag, "_data"},  o_rsp_data, '0);
        chk({tag, "_err"},   LW'(o_rsp_err), '0);
        chk({tag, "_en"},    LW'(o_simd_en), '0);
        chk({tag, "_in1"},   o_simd_in1, '0);
        chk({tag, "_in2"},   o_simd_in2, '0);
        chk({tag, "_op"},    LW'(o_simd_opcode), '0);
    endtask

    // Called in the ISSUE cycle; delivers a result after 'delay' WAIT cycles and ends in IDLE.
    task automatic respond(input string tag, input int delay, input logic [LW-1:0] data, input logic [NR-1:0] own);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, "_wait_grant"}, LW'(o_grant), '0);
            chk({tag, "_wait_en"}, LW'(o_simd_en), '0);
        end
        i_simd_valid  = 1'b1;
        i_simd_output = data;
        tick();
        i_simd_valid  = 1'b0;
        i_simd_output = '1;
        chk({tag, "_rspv"}, LW'(o_rsp_valid), LW'(own));
        chk({tag, "_data"}, o_rsp_data, data);
        chk({tag, "_err"}, LW'(o_rsp_err), '0);
        tick();
        chk({tag, "_rspv_pulse"}, LW'(o_rsp_valid), '0);
        chk({tag, "_data_hold"}, o_rsp_data, data);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [NR-1:0] e;
        rst = 1'b1; i_req = '0; i_in1 = '0; i_in2 = '0; i_opcode = '0;
        i_simd_output = '0; i_simd_valid = 1'b0; i_simd_busy = 1'b0;
        tick();
        tick();
        chk_zero_outputs("reset");
        rst = 1'b0;

        // Single add: 1.5 + 1.5 in lane 3
        set_op(0, 22'h0F8000, 22'h0F8000, 3'b000);
        i_req = 4'b0001;
        tick();
        chk("add_grant", LW'(o_grant), LW'(4'b0001));
        chk("add_en", LW'(o_simd_en), LW'(1'b1));
        chk("add_in1", o_simd_in1, lane3(22'h0F8000));
        chk("add_in2", o_simd_in2, lane3(22'h0F8000));
        chk("add_op", LW'(o_simd_opcode), '0);
        i_req = '0;
        respond("add", 2, lane3(22'h108000), 4'b0001);

        // Full contention from ptr 0
        do_reset();
        for (int k = 0; k < NR; k++) set_op(k, 22'(k + 1), 22'(k + 2), 3'(k));
        i_req = 4'b1111;
        for (int it = 0; it < 5; it++) begin
            e = 4'b0001 << (it % NR);
            wait_grant(10, n);
            chk("cont_grant", LW'(o_grant), LW'(e));
            chk("cont_latency", LW'(n), LW'(1));
            chk("cont_in1", o_simd_in1, lane3(22'((it % NR) + 1)));
            respond("cont", 1, lane3(22'(it + 16)), e);
        end
        i_req = '0;

        // Busy stall
        do_reset();
        set_op(2, 22'h012345, 22'h000777, 3'b011);
        i_simd_busy = 1'b1;
        i_req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_en", LW'(o_simd_en), '0);
            chk("busy_grant", LW'(o_grant), '0);
        end
        i_simd_busy = 1'b0;
        tick();
        chk("busy_grant_release", LW'(o_grant), LW'(4'b0100));
        chk("busy_op", LW'(o_simd_opcode), LW'(3'b011));
        i_req = '0;
        respond("busy", 1, lane3(22'h000003), 4'b0100);

        // Timeout: ptr is 3, requester 1 wins
        set_op(1, 22'h0A0000, 22'h0B0000, 3'b000);
        i_req = 4'b0010;
        tick();
        chk("to_grant", LW'(o_grant), LW'(4'b0010));
        i_req = '0;
        i_simd_output = '1;
        n = 0;
        while (o_rsp_valid == '0 && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", LW'(n), LW'(65));
        chk("to_rspv", LW'(o_rsp_valid), LW'(4'b0010));
        chk("to_err", LW'(o_rsp_err), LW'(1'b1));
        chk("to_data", o_rsp_data, '0);
        tick();

        // Valid coincident with last watchdog cycle: ptr is 2, requester 0 wins
        set_op(0, 22'h0C0000, 22'h0D0000, 3'b001);
        i_req = 4'b0001;
        tick();
        chk("tc_grant", LW'(o_grant), LW'(4'b0001));
        i_req = '0;
        for (int i = 0; i < TO; i++) tick();
        chk("tc_no_early", LW'(o_rsp_valid), '0);
        i_simd_valid  = 1'b1;
        i_simd_output = lane3(22'h00002A);
        tick();
        i_simd_valid  = 1'b0;
        chk("tc_rspv", LW'(o_rsp_valid), LW'(4'b0001));
        chk("tc_err", LW'(o_rsp_err), '0);
        chk("tc_data", o_rsp_data, lane3(22'h00002A));
        tick();

        // Reset mid-op: ptr is 1, requester 2 wins, ptr would become 3
        set_op(2, 22'h033333, 22'h044444, 3'b011);
        i_req = 4'b0100;
        tick();
        chk("rm_grant", LW'(o_grant), LW'(4'b0100));
        i_req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero_outputs("rm_reset");
        i_simd_valid  = 1'b1;
        i_simd_output = lane3(22'h000055);
        tick();
        i_simd_valid  = 1'b0;
        chk("rm_stale_rspv", LW'(o_rsp_valid), '0);
        tick();
        chk("rm_stale_rspv2", LW'(o_rsp_valid), '0);
        chk("rm_stale_data", o_rsp_data, '0);
        set_op(1, 22'h000101, 22'h000202, 3'b000);
        set_op(3, 22'h000303, 22'h000404, 3'b000);
        i_req = 4'b1010;
        tick();
        chk("rm_ptr0_grant", LW'(o_grant), LW'(4'b0010));
        i_req = '0;
        respond("rm_after", 1, lane3(22'h000077), 4'b0010);

        // Reduce chain on requester 1: ptr is 2
        set_op(1, 22'h0F8000, 22'h0F8000, 3'b000);
        i_req = 4'b0010;
        tick();
        chk("red1_grant", LW'(o_grant), LW'(4'b0010));
        chk("red1_op", LW'(o_simd_opcode), '0);
        i_req = '0;
        respond("red1", 2, lane3(22'h108000), 4'b0010);
        set_op(1, 22'h108000, 22'h108000, 3'b100);
        i_req = 4'b0010;
        tick();
        chk("red2_grant", LW'(o_grant), LW'(4'b0010));
        chk("red2_op", LW'(o_simd_opcode), LW'(3'b100));
        chk("red2_in1", o_simd_in1, lane3(22'h108000));
        i_req = '0;
        respond("red2", 3, lane3(22'h118000), 4'b0010);
        set_op(2, 22'h000001, 22'h000001, 3'b000);
        i_req = 4'b0111;
        tick();
        chk("red_ptr2_grant", LW'(o_grant), LW'(4'b0100));
        i_req = '0;
        respond("red_ptr2", 1, lane3(22'h000009), 4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
